// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the main-memory arbiter and the cache controllers:
// state encoding, default memory/block geometry, block address helper.
package mem_arbiter_pkg;

    localparam int DEF_MEM_LAT   = 4;
    localparam int DEF_BLK_WORDS = 8;
    localparam int DEF_WORD_BITS = 3;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FILL_I = 2'd1;
    localparam logic [1:0] ST_FILL_D = 2'd2;
    localparam logic [1:0] ST_WRITE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        FILL_I = ST_FILL_I,
        FILL_D = ST_FILL_D,
        WRITE  = ST_WRITE
    } arb_state_t;

    // Byte address of the first word of the block holding addr.
    function automatic logic [15:0] blk_base(
        input logic [15:0] addr,
        input int          wb
    );
        return addr & ~((16'(1) << (wb + 1)) - 16'(1));
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side signal bundle of the memory arbiter.
// master: arbiter view; slave: caches + memory view.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic                     i_req;
    logic [15:0]              i_addr;
    logic                     d_req;
    logic                     d_wr;
    logic [15:0]              d_addr;
    logic [15:0]              d_wdata;
    logic [15:0]              mem_rdata;
    logic [15:0]              mem_addr;
    logic                     mem_enable;
    logic                     mem_wr;
    logic [15:0]              mem_wdata;
    logic [15:0]              fill_data;
    logic [DEF_WORD_BITS-1:0] fill_word;
    logic                     i_fill_valid;
    logic                     d_fill_valid;
    logic                     i_done;
    logic                     d_done;
    logic                     busy;

    modport master (
        input  i_req, i_addr,
        input  d_req, d_wr, d_addr, d_wdata,
        input  mem_rdata,
        output mem_addr, mem_enable, mem_wr, mem_wdata,
        output fill_data, fill_word,
        output i_fill_valid, d_fill_valid,
        output i_done, d_done, busy
    );

    modport slave (
        output i_req, i_addr,
        output d_req, d_wr, d_addr, d_wdata,
        output mem_rdata,
        input  mem_addr, mem_enable, mem_wr, mem_wdata,
        input  fill_data, fill_word,
        input  i_fill_valid, d_fill_valid,
        input  i_done, d_done, busy
    );

endinterface

// File: rtl/mem_ret_pipe.sv
// Read-return tracker: DEPTH-stage {valid,index} shift register, async clear.
// Ports: clk, rst (active-low), push_valid_i/push_idx_i in, tap_valid_o/tap_idx_o out.
module mem_ret_pipe
    import mem_arbiter_pkg::*;
#(
    parameter int DEPTH = DEF_MEM_LAT,
    parameter int IW    = DEF_WORD_BITS
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_valid_i,
    input  logic [IW-1:0] push_idx_i,
    output logic          tap_valid_o,
    output logic [IW-1:0] tap_idx_o
);

    logic [DEPTH-1:0] vld_q;
    logic [IW-1:0]    idx_q [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                idx_q[s] <= '0;
            end
        end else begin
            vld_q[0] <= push_valid_i;
            idx_q[0] <= push_idx_i;
            for (int s = 1; s < DEPTH; s++) begin
                vld_q[s] <= vld_q[s-1];
                idx_q[s] <= idx_q[s-1];
            end
        end
    end

    assign tap_valid_o = vld_q[DEPTH-1];
    assign tap_idx_o   = idx_q[DEPTH-1];

endmodule

// File: rtl/mem_arbiter.sv
// Main-memory arbiter: I/D block fills over a fixed-latency pipelined memory
// plus single-word D writes. Ports: clk, rst (async, active-low), bus (master).
// Optional ARB_RR_EN: round-robin on simultaneous requests (else D over I).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MEM_LAT   = DEF_MEM_LAT,
    parameter int BLK_WORDS = DEF_BLK_WORDS,
    parameter int WORD_BITS = DEF_WORD_BITS
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);

    localparam int CNT_W = WORD_BITS + 1;

    arb_state_t           state_q, state_d;
    logic [15:0]          addr_q, addr_d;
    logic [15:0]          wdata_q, wdata_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 grant_d;
    logic                 issue;
    logic                 tap_v;
    logic [WORD_BITS-1:0] tap_idx;
    logic                 last_ret;
    logic [15:0]          maddr;
    logic [15:0]          mwdata;
    logic                 men;
    logic                 mwr;
    logic                 idone;
    logic                 ddone;

`ifdef ARB_RR_EN
    logic last_d_q, last_d_d;

    // On a tie, the side not served last wins.
    always_comb begin
        grant_d = bus.d_req;
        if (bus.d_req && bus.i_req) begin
            grant_d = !last_d_q;
        end
    end

    always_comb begin
        last_d_d = last_d_q;
        if (state_q == IDLE && (bus.d_req || bus.i_req)) begin
            last_d_d = grant_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_d_q <= 1'b0;
        end else begin
            last_d_q <= last_d_d;
        end
    end
`else
    assign grant_d = bus.d_req;
`endif

    assign issue = (state_q == FILL_I || state_q == FILL_D)
                && (cnt_q < CNT_W'(BLK_WORDS));

    mem_ret_pipe #(
        .DEPTH (MEM_LAT),
        .IW    (WORD_BITS)
    ) u_ret (
        .clk          (clk),
        .rst          (rst),
        .push_valid_i (issue),
        .push_idx_i   (cnt_q[WORD_BITS-1:0]),
        .tap_valid_o  (tap_v),
        .tap_idx_o    (tap_idx)
    );

    assign last_ret = tap_v && (tap_idx == WORD_BITS'(BLK_WORDS - 1));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        maddr   = '0;
        mwdata  = '0;
        men     = 1'b0;
        mwr     = 1'b0;
        idone   = 1'b0;
        ddone   = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (grant_d) begin
                    addr_d  = bus.d_addr;
                    wdata_d = bus.d_wdata;
                    state_d = bus.d_wr ? WRITE : FILL_D;
                end else if (bus.i_req) begin
                    addr_d  = bus.i_addr;
                    wdata_d = '0;
                    state_d = FILL_I;
                end
            end
            FILL_I, FILL_D: begin
                if (issue) begin
                    men   = 1'b1;
                    maddr = blk_base(addr_q, WORD_BITS)
                          | 16'({cnt_q[WORD_BITS-1:0], 1'b0});
                    cnt_d = cnt_q + 1'b1;
                end
                // Completion follows the final return, not the final issue.
                if (last_ret) begin
                    state_d = IDLE;
                    idone   = (state_q == FILL_I);
                    ddone   = (state_q == FILL_D);
                end
            end
            WRITE: begin
                men     = 1'b1;
                mwr     = 1'b1;
                maddr   = addr_q;
                mwdata  = wdata_q;
                ddone   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.mem_addr     = maddr;
    assign bus.mem_enable   = men;
    assign bus.mem_wr       = mwr;
    assign bus.mem_wdata    = mwdata;
    assign bus.fill_data    = tap_v ? bus.mem_rdata : '0;
    assign bus.fill_word    = tap_v ? tap_idx : '0;
    assign bus.i_fill_valid = tap_v && (state_q == FILL_I);
    assign bus.d_fill_valid = tap_v && (state_q == FILL_D);
    assign bus.i_done       = idone;
    assign bus.d_done       = ddone;
    assign bus.busy         = (state_q != IDLE);

endmodule
